// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative integer multiply / divide unit. Radix-2 shift-add
//             multiply and restoring shift-subtract divide on operand
//             magnitudes, followed by a sign-correction stage. One result
//             word (low/high product, quotient/remainder) is selected by op.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             stall
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // Latched operation: divide flag, upper-word select, operand signs
  logic               is_div;
  logic               sel_hi;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {partial sum, multiplier}. Divide: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic               fix_phase;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               in_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic               neg_res;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fix_next;

  assign accept    = (state == IDLE) && start && !flush;
  assign in_signed = ~op[0];
  assign in_neg_a  = in_signed & a[WIDTH-1];
  assign in_neg_b  = in_signed & b[WIDTH-1];
  assign abs_a     = in_neg_a ? -a : a;
  assign abs_b     = in_neg_b ? -b : b;

  // One shift-add step: add multiplicand when the multiplier LSB is set, shift right
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring-divide step; a clear borrow bit means the trial subtract fits.
  // With a zero divisor the remainder simply collects the dividend; the quotient
  // is overridden during sign correction.
  always_comb begin
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_trial - {1'b0, mag_b};
    div_ge    = ~div_diff[WIDTH];
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_ge};
  end

  // Sign correction of the magnitude results
  always_comb begin
    neg_res  = sign_a ^ sign_b;
    quo_fix  = b_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_next = acc;
    if (is_div) begin
      fix_next = {rem_fix, quo_fix};
    end else if (neg_res) begin
      fix_next = -acc;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     if (fix_phase) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Datapath: operand capture, iteration, sign fix, then result word select
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      is_div    <= 1'b0;
      sel_hi    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      cnt       <= '0;
      acc       <= '0;
      fix_phase <= 1'b0;
      result_q  <= '0;
    end else begin
      fix_phase <= 1'b0;
      if (accept) begin
        is_div <= op[2];
        sel_hi <= op[1];
        sign_a <= in_neg_a;
        sign_b <= in_neg_b;
        b_zero <= (b == '0);
        mag_a  <= abs_a;
        mag_b  <= abs_b;
        cnt    <= CNT_W'(WIDTH);
        acc    <= op[2] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
      end else if (!flush) begin
        case (state)
          CALC: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
          end
          FIX: begin
            if (!fix_phase) begin
              acc       <= fix_next;
              fix_phase <= 1'b1;
            end else begin
              result_q <= sel_hi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_q;
  assign stall  = start & ~done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit (WIDTH = 32) with a
//             plain-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         stall;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  // Reference: full-precision integer arithmetic, then pick the word
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o[2]) begin
      if (o[0]) p = {32'd0, x} * {32'd0, y};
      else      p = 64'(sx * sy);
      return o[1] ? p[63:32] : p[31:0];
    end
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? (x % y) : (x / y);
    q = sx / sy;
    r = sx % sy;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE (caller sits just after an edge); return at the done cycle
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'b000; a = 32'd3; b = 32'd4;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b expected 1", stall); end
    rst = 1'b0;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_accept_busy: got %b expected 1", busy); end
    k = 0;
    while (done !== 1'b1 && k < 100) begin tick(); k++; end
    n_cmp++; if (k !== LAT) begin n_err++; $display("FAIL first_accept_latency: got %0d expected %0d", k, LAT); end
    n_cmp++; if (result !== 32'd12) begin n_err++; $display("FAIL first_accept_result: got %h expected %h", result, 32'd12); end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [10] = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] t_a  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                               32'h8000_0000, 32'h8000_0000, 32'h1234, 32'h1234};
    logic [31:0] t_b  [10] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_e  [10] = '{32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD,
                               32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      tick();
      run_op(t_op[i], t_a[i], t_b[i], res, lat);
      n_cmp++; if (res !== t_e[i]) begin n_err++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, t_e[i]); end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, LAT); end
    end
    repeat (3) tick();
    n_cmp++; if (result !== t_e[9]) begin n_err++; $display("FAIL result_hold: got %h expected %h", result, t_e[9]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, res, exp_r;
    int lat;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom);
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = $urandom_range(1, 15);
        default: y = $urandom;
      endcase
      exp_r = model(o, x, y);
      tick();
      run_op(o, x, y, res, lat);
      n_cmp++; if (res !== exp_r) begin n_err++; $display("FAIL random_%0d op=%b a=%h b=%h: got %h expected %h", i, o, x, y, res, exp_r); end
      n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, prev_e, new_e;
    int lat;
    prev_e = model(3'b000, 32'd1234, 32'hFFFF_FF00);
    tick();
    run_op(3'b000, 32'd1234, 32'hFFFF_FF00, res, lat);
    n_cmp++; if (res !== prev_e) begin n_err++; $display("FAIL flush_setup: got %h expected %h", res, prev_e); end
    tick();
    op = 3'b100; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b expected 0", done); end
    n_cmp++; if (result !== prev_e) begin n_err++; $display("FAIL flush_result_kept: got %h expected %h", result, prev_e); end
    new_e = model(3'b101, 32'd1000, 32'd7);
    run_op(3'b101, 32'd1000, 32'd7, res, lat);
    n_cmp++; if (res !== new_e) begin n_err++; $display("FAIL after_flush_result: got %h expected %h", res, new_e); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL after_flush_latency: got %0d expected %0d", lat, LAT); end
    tick();
    start = 1'b1; flush = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_beats_start: got %b expected 0", busy); end
    start = 1'b0; flush = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_beats_start_later: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2, r1, r2;
    int d1, d2, pulses;
    e1 = model(3'b010, 32'h8765_4321, 32'h1234_5678);
    e2 = model(3'b110, 32'hF000_0001, 32'd9);
    d1 = -1; d2 = -1; pulses = 0; r1 = '0; r2 = '0;
    op = 3'b010; a = 32'h8765_4321; b = 32'h1234_5678; start = 1'b1;
    tick();
    op = 3'b110; a = 32'hF000_0001; b = 32'd9;
    for (int k = 1; k <= 75; k++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        if (d1 < 0) begin d1 = k; r1 = result; end
        else begin d2 = k; r2 = result; end
      end
      if (k == 5) begin
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_busy: got %b expected 1", stall); end
      end
      if (k == 36) start = 1'b0;
    end
    n_cmp++; if (d1 !== LAT) begin n_err++; $display("FAIL b2b_first_done: got %0d expected %0d", d1, LAT); end
    n_cmp++; if (d2 !== 2 * LAT + 2) begin n_err++; $display("FAIL b2b_second_done: got %0d expected %0d", d2, 2 * LAT + 2); end
    n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    n_cmp++; if (r1 !== e1) begin n_err++; $display("FAIL b2b_result1: got %h expected %h", r1, e1); end
    n_cmp++; if (r2 !== e2) begin n_err++; $display("FAIL b2b_result2: got %h expected %h", r2, e2); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    tick();
    op = 3'b000; a = $urandom; b = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL midreset_result: got %h expected 0", result); end
    pulses = 0;
    repeat (40) begin tick(); if (done === 1'b1) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d expected 0", pulses); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
